// File: rtl/mux2_sel_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mux2_sel_arbiter_if
// Brief    : Request/grant/select bundle between two requesters and the arbiter.
// Revision : 1.0
// ============================================================================
interface mux2_sel_arbiter_if;
  logic req0;
  logic req1;
  logic sel;
  logic gnt0;
  logic gnt1;
  logic busy;

  modport master (
    output req0,
    output req1,
    input  sel,
    input  gnt0,
    input  gnt1,
    input  busy
  );

  modport slave (
    input  req0,
    input  req1,
    output sel,
    output gnt0,
    output gnt1,
    output busy
  );
endinterface
`default_nettype wire

// File: rtl/mux2_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux2_sel_arbiter
// Brief    : Two-channel round-robin arbiter with minimum dwell under contention,
//            producing a registered, glitch-free 2:1 mux select.
// Revision : 1.0
// ============================================================================
module mux2_sel_arbiter #(
  parameter int HOLD  = 4,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mux2_sel_arbiter_if.slave    bus
);

  // One-hot grant states so each grant output is a single flop bit.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             last_q,  last_d;
  logic             sel_q,   sel_d;
  logic             busy_q,  busy_d;

  logic             enter_en;
  logic             enter_ch;
  logic             cnt_sat;

  assign cnt_sat = (cnt_q == HOLD_M1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    sel_d    = sel_q;
    enter_en = 1'b0;
    enter_ch = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.req0 && bus.req1) begin
          enter_en = 1'b1;
          enter_ch = ~last_q;
        end else if (bus.req0) begin
          enter_en = 1'b1;
          enter_ch = 1'b0;
        end else if (bus.req1) begin
          enter_en = 1'b1;
          enter_ch = 1'b1;
        end
      end

      G0: begin
        if (!bus.req0) begin
          if (bus.req1) begin
            enter_en = 1'b1;
            enter_ch = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (bus.req1 && cnt_sat) begin
          enter_en = 1'b1;
          enter_ch = 1'b1;
        end else if (!cnt_sat) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      G1: begin
        if (!bus.req1) begin
          if (bus.req0) begin
            enter_en = 1'b1;
            enter_ch = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else if (bus.req0 && cnt_sat) begin
          enter_en = 1'b1;
          enter_ch = 1'b0;
        end else if (!cnt_sat) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // Every grant entry restarts the dwell and records the winner.
    if (enter_en) begin
      state_d = enter_ch ? G1 : G0;
      cnt_d   = '0;
      last_d  = enter_ch;
      sel_d   = enter_ch;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
    end
  end

  // busy has its own flop so a G0<->G1 handoff cannot glitch it low.
  assign bus.gnt0 = state_q[0];
  assign bus.gnt1 = state_q[1];
  assign bus.sel  = sel_q;
  assign bus.busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mux2_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux2_sel_arbiter
// Brief    : Directed vectors with queued expectations checked by a monitor.
// Revision : 1.0
// ============================================================================
module tb_mux2_sel_arbiter;

  logic clk;
  logic rst;

  mux2_sel_arbiter_if bus_if ();

  mux2_sel_arbiter #(
    .HOLD  (4),
    .CNT_W (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {gnt0, gnt1, sel, busy} after the next rising edge.
  logic [3:0] exp_q[$];
  string      name_q[$];
  int         n_total;
  int         n_pass;

  task automatic step(input string nm, input logic r, input logic a, input logic b,
                      input logic g0, input logic g1, input logic s);
    @(negedge clk);
    rst         = r;
    bus_if.req0 = a;
    bus_if.req1 = b;
    exp_q.push_back({g0, g1, s, g0 | g1});
    name_q.push_back(nm);
  endtask

  task automatic repeat_step(input int n, input string nm, input logic r, input logic a,
                             input logic b, input logic g0, input logic g1, input logic s);
    for (int i = 0; i < n; i++) step(nm, r, a, b, g0, g1, s);
  endtask

  // Monitor: outputs are presented every cycle; compare 1 time unit past the edge.
  initial begin
    logic [3:0] exp_v;
    logic [3:0] act_v;
    string      nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        nm    = name_q.pop_front();
        act_v = {bus_if.gnt0, bus_if.gnt1, bus_if.sel, bus_if.busy};
        n_total++;
        if (act_v === exp_v) n_pass++;
        else $display("FAIL %s: {gnt0,gnt1,sel,busy} got %b expected %b at %0t",
                      nm, act_v, exp_v, $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_total     = 0;
    n_pass      = 0;
    rst         = 1'b1;
    bus_if.req0 = 1'b0;
    bus_if.req1 = 1'b0;

    // Reset held with both requests active
    repeat_step(2, "reset_hold",     1, 1, 1, 0, 0, 0);
    // Contention from reset: last=1 so channel 0 first, 4 cycles each
    repeat_step(4, "cont_g0_a",      0, 1, 1, 1, 0, 0);
    repeat_step(4, "cont_g1",        0, 1, 1, 0, 1, 1);
    repeat_step(4, "cont_g0_b",      0, 1, 1, 1, 0, 0);
    step       (   "release_idle",   0, 0, 0, 0, 0, 0);
    // Single 3-cycle request on channel 0
    repeat_step(3, "single_req0",    0, 1, 0, 1, 0, 0);
    step       (   "single_idle",    0, 0, 0, 0, 0, 0);
    // Long uncontended grant on channel 1, then contention after saturation
    repeat_step(10, "long_req1",     0, 0, 1, 0, 1, 1);
    step       (   "sat_switch",     0, 1, 1, 1, 0, 0);
    repeat_step(3, "after_switch",   0, 1, 1, 1, 0, 0);
    // Direct handoff G0 -> G1
    step       (   "handoff",        0, 0, 1, 0, 1, 1);
    step       (   "g1_both",        0, 1, 1, 0, 1, 1);
    // Reset while in G1 with both requests
    step       (   "reset_mid",      1, 1, 1, 0, 0, 0);
    step       (   "post_reset_g0",  0, 1, 1, 1, 0, 0);
    // Handoff to G1 then idle: sel must hold 1
    step       (   "handoff_b",      0, 0, 1, 0, 1, 1);
    step       (   "idle_sel_hold",  0, 0, 0, 0, 0, 1);
    // IDLE tie-break with last=1 then last=0
    step       (   "tie_last1",      0, 1, 1, 1, 0, 0);
    step       (   "tie_hold",       0, 1, 1, 1, 0, 0);
    step       (   "idle_again",     0, 0, 0, 0, 0, 0);
    step       (   "tie_last0",      0, 1, 1, 0, 1, 1);
    step       (   "release_g1",     0, 0, 0, 0, 0, 1);

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: pending expectations got %0d expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
